// File: rtl/codec_frame_serializer.sv
// Codec-side frame pacer and I2S transmitter: paces the player with new_frame, captures one
// mono sample per frame, sends it on both channels and counts frames with no fresh sample.
module codec_frame_serializer #(
   parameter int unsigned HALF_BIT  = 16,
   parameter int unsigned SLOT_BITS = 32,
   parameter int unsigned SAMPLE_W  = 18
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic [SAMPLE_W-1:0] i_sample_in,
   input  logic                i_sample_strobe,
   output logic                o_new_frame,
   output logic                o_bclk,
   output logic                o_lrclk,
   output logic                o_sdata,
   output logic [7:0]          o_miss_count
);

   localparam int unsigned NBITS = 2 * SLOT_BITS;
   localparam int unsigned FRAME = NBITS * 2 * HALF_BIT;
   localparam int unsigned HW    = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
   localparam int unsigned BW    = $clog2(NBITS);

   logic [HW-1:0]       r_half_cnt;
   logic                r_bclk;
   logic [BW-1:0]       r_bit_idx;
   logic                r_new_frame;
   logic                r_lrclk;
   logic                r_sdata;
   logic [SAMPLE_W-1:0] r_hold;
   logic                r_tx_en;
   logic                r_seen;
   logic [7:0]          r_miss_count;

   logic [HW-1:0]       w_half_nxt;
   logic                w_bclk_nxt;
   logic [BW-1:0]       w_bit_nxt;
   logic [31:0]         w_pos;
   logic [31:0]         w_slot_nxt;
   logic                w_sdata_nxt;
   logic                w_capture;
   logic                w_miss;

   always_comb begin
      w_half_nxt = r_half_cnt + 1'b1;
      w_bclk_nxt = r_bclk;
      w_bit_nxt  = r_bit_idx;
      if (r_half_cnt == HW'(HALF_BIT - 1)) begin
         w_half_nxt = '0;
         w_bclk_nxt = ~r_bclk;
         if (r_bclk) begin
            w_bit_nxt = (r_bit_idx == BW'(NBITS - 1)) ? '0 : r_bit_idx + 1'b1;
         end
      end
   end

   assign w_pos = 32'(r_bit_idx) * (2 * HALF_BIT) + (r_bclk ? HALF_BIT : 32'd0)
                  + 32'(r_half_cnt);
   assign w_capture = (w_pos == 32'd2);
   assign w_miss    = ~(r_seen | i_sample_strobe);

   // Data for the slot the next bit period belongs to, so sdata moves with bclk's fall.
   always_comb begin
      w_slot_nxt = 32'(w_bit_nxt);
      if (w_slot_nxt >= SLOT_BITS) begin
         w_slot_nxt = w_slot_nxt - SLOT_BITS;
      end
      w_sdata_nxt = 1'b0;
      for (int unsigned i = 0; i < SAMPLE_W; i++) begin
         if (w_slot_nxt == SAMPLE_W - i) begin
            w_sdata_nxt = r_hold[i] & r_tx_en;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_half_cnt   <= '0;
         r_bclk       <= 1'b0;
         r_bit_idx    <= '0;
         r_new_frame  <= 1'b0;
         r_lrclk      <= 1'b0;
         r_sdata      <= 1'b0;
         r_hold       <= '0;
         r_tx_en      <= 1'b0;
         r_seen       <= 1'b1;
         r_miss_count <= 8'd0;
      end else begin
         r_half_cnt  <= w_half_nxt;
         r_bclk      <= w_bclk_nxt;
         r_bit_idx   <= w_bit_nxt;
         r_new_frame <= (w_pos == FRAME - 2);
         r_lrclk     <= (w_bit_nxt >= BW'(SLOT_BITS));
         r_sdata     <= w_sdata_nxt;
         if (w_capture) begin
            r_hold  <= i_sample_in;
            r_tx_en <= i_enable;
            // A strobe on the capture edge is consumed here, never carried forward.
            r_seen  <= 1'b0;
            if (w_miss && (r_miss_count != 8'hFF)) begin
               r_miss_count <= r_miss_count + 8'd1;
            end
         end else begin
            r_seen <= r_seen | i_sample_strobe;
         end
      end
   end

   assign o_new_frame  = r_new_frame;
   assign o_bclk       = r_bclk;
   assign o_lrclk      = r_lrclk;
   assign o_sdata      = r_sdata;
   assign o_miss_count = r_miss_count;

endmodule

// File: doc/codec_frame_serializer.md
Name: codec_frame_serializer

Overview:
- Codec-side end of the player's sample interface.
- Generates the 48 kHz new_frame pulse that paces music_player.
- Captures the player's 18-bit sample_out once per frame and serialises it as an I2S stereo stream (bclk/lrclk/sdata), sending the same mono sample on both channels.
- Counts frames in which the player failed to produce a fresh sample.

Parameters:
- HALF_BIT, 16: clk cycles per bclk half-period (bclk = clk/32).
- SLOT_BITS, 32: bit slots per channel. Frame = 2*SLOT_BITS*2*HALF_BIT = 2048 clk cycles.
- SAMPLE_W, 18: sample width, two's complement, sent MSB first. Must satisfy SAMPLE_W <= SLOT_BITS-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset (asserted at 0)
- enable  input  1  1 = transmit captured sample; 0 = transmit zeros
- sample_in  input  SAMPLE_W  sample from player (music_player sample_out)
- sample_strobe  input  1  one-cycle pulse when player produced a sample (new_sample_generated)
- new_frame  output  1  one-cycle frame pulse to player
- bclk  output  1  serial bit clock
- lrclk  output  1  channel select: 0 = left, 1 = right
- sdata  output  1  serial data; changes on bclk falling edge
- miss_count  output  8  saturating count of frames with no fresh sample

Behaviour:
- Frame position c = bit_idx*2*HALF_BIT + bclk*HALF_BIT + half_cnt, range 0..2047.
- half_cnt counts 0..HALF_BIT-1. bclk toggles on each half_cnt wrap. bit_idx (0..2*SLOT_BITS-1) increments when bclk goes 1->0 and wraps at frame end. All free-running, no stall.
- Reset (reset=0, asynchronous): all counters 0, bclk=lrclk=sdata=new_frame=0, miss_count=0, hold=0, tx_en=0, seen=1.
- After reset release, the first clock edge enters c=1. Frame 0 begins at c=0 with reset held.
- new_frame=1 only while c==2047; otherwise 0. Period exactly 2048 cycles.
- Capture at the clock edge leaving c==2 (three cycles after new_frame):
  - hold <= sample_in; tx_en <= enable.
  - The captured value is transmitted in the current frame.
  - enable changes at any other time have no effect until the next capture.
- lrclk = 0 for bit_idx 0..SLOT_BITS-1 and 1 for SLOT_BITS..2*SLOT_BITS-1 (registered alongside bclk).
- sdata per channel slot s (0..SLOT_BITS-1), registered so it is valid for the whole bit period:
  - s=0: I2S delay bit, always 0.
  - s=1..SAMPLE_W: hold[SAMPLE_W-s], gated by tx_en.
  - s>SAMPLE_W: 0.
- Bit-0 data is presented before capture. It is constant 0, so the capture timing cannot corrupt it.
- Right channel repeats the same hold bits.
- Miss detection at the capture edge:
  - miss = !(seen | sample_strobe).
  - If miss and miss_count != 255, miss_count increments. It saturates at 255 and never wraps.
  - seen <= 0 at the capture edge.
  - Otherwise seen <= seen | sample_strobe.
  - A strobe coincident with the capture edge satisfies that capture and is consumed; it does not carry into the next frame.
  - seen resets to 1, so the first capture after reset never counts as a miss.
- Multiple strobes in one frame are equivalent to one.
- The sample value is captured regardless of strobe; a miss still transmits whatever sample_in holds.
- Reset mid-frame: outputs go to reset values immediately. The frame restarts from c=0 after release; a partial frame is never completed.
- No other state. Latency sample_in -> first sdata bit (MSB) = capture + 2*HALF_BIT - 3 cycles, i.e. MSB driven from c=32.

Test Plan:
- Hold reset=0 for 5 cycles, then release -> all outputs 0 during reset. First new_frame at cycle 2047 after release (c counted from 0), width 1. miss_count=0.
- Free run 10 frames -> new_frame period exactly 2048; bclk period 32 with 50% duty; lrclk toggles every 1024 cycles.
- sample_in=18'h2AAAA with a strobe each frame, enable=1 -> deserialiser on bclk rising edges gets left slots 1..18 = 101010...10, slots 0 and 19..31 = 0, right identical. Repeat with 18'h20001 (sign bit and LSB).
- Strobe in frames 1–3, none in frames 4–5, strobe exactly on the capture edge in frame 6 -> miss_count 0,0,0,1,2,2. Force 255 misses -> stays 255.
- enable=0 at capture -> whole frame sdata=0 while new_frame and clocks continue. Raise enable at c=100 -> still zero this frame; data appears next frame.
- Drop reset at c=500 without a clock edge -> outputs 0 immediately. Release -> next new_frame 2047 cycles later, miss_count=0.
